register_demux: RTL and testbench



---
 rtl/register_demux_if.sv | 27 ++
 rtl/register_demux.sv | 93 +++++++++
 tb/tb_register_demux.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/register_demux_if.sv
// Write-side bus of the register demux: request/stall inputs, register outputs
// and the commit report. The slave modport is the demux, the master the requester.
interface register_demux_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DIN;
    logic [1:0]       S;
    logic             WE;
    logic             HOLD;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic             BUSY;
    logic             DONE;
    logic [1:0]       DONE_SEL;

    modport slave (
        input  DIN, S, WE, HOLD,
        output A, B, C, D, BUSY, DONE, DONE_SEL
    );

    modport master (
        output DIN, S, WE, HOLD,
        input  A, B, C, D, BUSY, DONE, DONE_SEL
    );
endinterface

// File: rtl/register_demux.sv
// 4-channel write demux into registers A-D behind a one-entry pending stage.
// Optional macro REGISTER_DEMUX_BYPASS_EN forwards pending data to its output.
module register_demux #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    register_demux_if.slave  bus
);
    logic [3:0][WIDTH-1:0] regs_q, regs_d;
    logic [3:0][WIDTH-1:0] view_s;
    logic                  pv_q, pv_d;
    logic [1:0]            ps_q, ps_d;
    logic [WIDTH-1:0]      pd_q, pd_d;
    logic                  done_q, done_d;
    logic [1:0]            done_sel_q, done_sel_d;
    logic                  busy_s;
    logic                  accept_s;
    logic                  commit_s;

    // Handshake qualifiers; a stalled full stage refuses new writes
    always_comb begin
        busy_s   = pv_q & bus.HOLD;
        accept_s = bus.WE & ~busy_s;
        commit_s = pv_q & ~bus.HOLD;
    end

    // Next state: commit uses the old pending entry, accept reloads it on the same edge
    always_comb begin
        regs_d     = regs_q;
        pv_d       = pv_q;
        ps_d       = ps_q;
        pd_d       = pd_q;
        done_d     = 1'b0;
        done_sel_d = done_sel_q;
        if (commit_s) begin
            regs_d[ps_q] = pd_q;
            done_d       = 1'b1;
            done_sel_d   = ps_q;
            pv_d         = 1'b0;
        end else begin
            done_d = 1'b0;
        end
        if (accept_s) begin
            pv_d = 1'b1;
            ps_d = bus.S;
            pd_d = bus.DIN;
        end else begin
            ps_d = ps_q;
        end
    end

    // State registers; reset discards any pending write
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regs_q     <= {(4*WIDTH){1'b0}};
            pv_q       <= 1'b0;
            ps_q       <= 2'b00;
            pd_q       <= {WIDTH{1'b0}};
            done_q     <= 1'b0;
            done_sel_q <= 2'b00;
        end else begin
            regs_q     <= regs_d;
            pv_q       <= pv_d;
            ps_q       <= ps_d;
            pd_q       <= pd_d;
            done_q     <= done_d;
            done_sel_q <= done_sel_d;
        end
    end

`ifdef REGISTER_DEMUX_BYPASS_EN
    // Readers see a pending write immediately, even while the commit is held
    always_comb begin
        view_s = regs_q;
        if (pv_q) begin
            view_s[ps_q] = pd_q;
        end else begin
            view_s = regs_q;
        end
    end
`else
    assign view_s = regs_q;
`endif

    assign bus.A        = view_s[0];
    assign bus.B        = view_s[1];
    assign bus.C        = view_s[2];
    assign bus.D        = view_s[3];
    assign bus.BUSY     = busy_s;
    assign bus.DONE     = done_q;
    assign bus.DONE_SEL = done_sel_q;
endmodule

// File: tb/tb_register_demux.sv
// Self-checking bench for register_demux: directed cases plus random traffic
// compared against a queue-based model of the pending stage.
module tb_register_demux;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } wr_t;

    logic CLK;
    logic RST_N;
    register_demux_if #(.WIDTH(W)) bus_if ();

    register_demux #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] mreg [4];
    wr_t          pq [$];
    logic         mdone;
    logic [1:0]   mdsel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [W-1:0] view(input int idx);
        logic [W-1:0] v;
        v = mreg[idx];
`ifdef REGISTER_DEMUX_BYPASS_EN
        if (pq.size() != 0 && pq[0].sel == idx[1:0]) v = pq[0].data;
`endif
        return v;
    endfunction

    function automatic logic [W-1:0] dut_out(input int idx);
        case (idx)
            0:       return bus_if.A;
            1:       return bus_if.B;
            2:       return bus_if.C;
            default: return bus_if.D;
        endcase
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        pq.delete();
        mdone = 1'b0;
        mdsel = 2'b00;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_reg%0d", tag, i), dut_out(i), view(i));
        chk({tag, "_done"}, bus_if.DONE, mdone);
        chk({tag, "_dsel"}, bus_if.DONE_SEL, mdsel);
    endtask

    // One clock cycle: drive, check BUSY mid-cycle, advance model on the edge, check registers
    task automatic cyc(input logic we, input logic [1:0] s, input logic [W-1:0] din, input logic hold);
        bit busy_e;
        wr_t e;
        bus_if.WE   = we;
        bus_if.S    = s;
        bus_if.DIN  = din;
        bus_if.HOLD = hold;
        @(negedge CLK);
        busy_e = (pq.size() != 0) && hold;
        chk("busy", bus_if.BUSY, busy_e);
        @(posedge CLK);
        if (pq.size() != 0 && !hold) begin
            e = pq.pop_front();
            mreg[e.sel] = e.data;
            mdone = 1'b1;
            mdsel = e.sel;
        end else begin
            mdone = 1'b0;
        end
        if (we && !busy_e) pq.push_back('{sel: s, data: din});
        #1;
        check_outputs("cyc");
    endtask

    logic         r_we, r_hold;
    logic [1:0]   r_s;
    logic [W-1:0] r_din;
    logic [W-1:0] exp_d;

    initial begin
        RST_N = 1'b0;
        bus_if.WE = 1'b0; bus_if.S = 2'b00; bus_if.DIN = '0; bus_if.HOLD = 1'b0;
        mdl_reset();
        #1;
        check_outputs("rst0");
        chk("rst0_busy", bus_if.BUSY, 1'b0);
        @(negedge CLK); @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Single writes to each destination
        cyc(1'b1, 2'd0, 8'h11, 1'b0);
        cyc(1'b1, 2'd1, 8'h22, 1'b0);
        chk("single_done_a", bus_if.DONE_SEL, 2'd0);
        cyc(1'b1, 2'd2, 8'h33, 1'b0);
        cyc(1'b1, 2'd3, 8'h44, 1'b0);
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        chk("single_a", bus_if.A, 8'h11);
        chk("single_b", bus_if.B, 8'h22);
        chk("single_c", bus_if.C, 8'h33);
        chk("single_d", bus_if.D, 8'h44);
        chk("single_dsel", bus_if.DONE_SEL, 2'd3);
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        chk("idle_done", bus_if.DONE, 1'b0);

        // Back-to-back writes to B
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'd1, 8'h05 + 8'(i), 1'b0);
        cyc(1'b0, 2'd1, 8'h00, 1'b0);
        chk("b2b_b", bus_if.B, 8'h08);
        chk("b2b_done", bus_if.DONE, 1'b1);

        // Stall: 0xBB refused while HOLD is high
        cyc(1'b1, 2'd2, 8'hAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'd2, 8'hBB, 1'b1);
            chk("stall_c", bus_if.C, 8'h33);
        end
        cyc(1'b1, 2'd2, 8'hBB, 1'b0);
        chk("stall_c_aa", bus_if.C, 8'hAA);
        cyc(1'b0, 2'd2, 8'h00, 1'b0);
        chk("stall_c_bb", bus_if.C, 8'hBB);

        // Pending write to D while stalled: forwarded only with bypass
        cyc(1'b1, 2'd3, 8'h5A, 1'b1);
        cyc(1'b0, 2'd3, 8'h00, 1'b1);
`ifdef REGISTER_DEMUX_BYPASS_EN
        exp_d = 8'h5A;
`else
        exp_d = 8'h44;
`endif
        chk("bypass_d", bus_if.D, exp_d);
        cyc(1'b0, 2'd3, 8'h00, 1'b0);
        chk("bypass_commit_d", bus_if.D, 8'h5A);

        // Random traffic; a refused request is held until accepted
        r_we = 1'b0; r_s = 2'b00; r_din = '0; r_hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(r_we && pq.size() != 0 && r_hold)) begin
                r_we  = ($urandom_range(0, 3) != 0);
                r_s   = 2'($urandom_range(0, 3));
                r_din = 8'($urandom);
            end
            r_hold = ($urandom_range(0, 2) == 0);
            cyc(r_we, r_s, r_din, r_hold);
        end

        // Reset while a write is pending and stalled
        cyc(1'b1, 2'd0, 8'h99, 1'b1);
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        cyc(1'b1, 2'd1, 8'h77, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        mdl_reset();
        check_outputs("rst_mid");
        chk("rst_mid_busy", bus_if.BUSY, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        cyc(1'b0, 2'd0, 8'h00, 1'b0);
        chk("rst_no_commit_a", bus_if.A, 8'h00);
        chk("rst_no_done", bus_if.DONE, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
